// File: rtl/cpu_pkg.sv
// Shared CPU constants: default register-file geometry and the hardwired-zero register index.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned ADDR_W_DEF   = 3;
  localparam int unsigned NUM_REGS_DEF = 8;
  localparam int unsigned REG_ZERO     = 0;

endpackage

// File: rtl/regfile_rd_stage.sv
// One read-pipe stage: data loads only alongside a valid token, valid shifts every cycle.
module regfile_rd_stage #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] d,
  output logic              vld_out,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_out <= 1'b0;
      q       <= '0;
    end else begin
      vld_out <= vld_in;
      if (vld_in) q <= d;
    end
  end

endmodule

// File: rtl/regfile_2r1w_pipe.sv
// Two-read one-write register file with write-first bypass, optional hardwired R0
// and a 1- or 2-stage registered read pipe.
module regfile_2r1w_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter bit          ZERO_REG = 1'b0,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid
);

  localparam int unsigned     DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic                         wr_ok_c;
  logic [DATA_W-1:0]            cap1_c;
  logic [DATA_W-1:0]            cap2_c;

  // Address maps to a real, writable register (not out of range, not the hardwired zero).
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_W) && !(ZERO_REG && (a == ADDR_W'(REG_ZERO)));
  endfunction

  assign wr_ok_c = wr_en && addr_live(wr_addr);

  // Unimplemented or hardwired-zero slots carry no flops and read as zero.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_reg
    if ((i < int'(NUM_REGS)) && !(ZERO_REG && (i == int'(REG_ZERO)))) begin : g_impl
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else if (wr_ok_c && (wr_addr == ADDR_W'(i))) q <= wr_data;
      end
      assign regs[i] = q;
    end else begin : g_tie
      assign regs[i] = '0;
    end
  end

  // Capture value with write-first bypass from a same-edge write.
  always_comb begin
    cap1_c = '0;
    cap2_c = '0;
    if (addr_live(rd_addr1)) begin
      cap1_c = (wr_en && (wr_addr == rd_addr1)) ? wr_data : regs[rd_addr1];
    end
    if (addr_live(rd_addr2)) begin
      cap2_c = (wr_en && (wr_addr == rd_addr2)) ? wr_data : regs[rd_addr2];
    end
  end

  logic [RD_LAT:0][DATA_W-1:0] p1_d;
  logic [RD_LAT:0][DATA_W-1:0] p2_d;
  logic [RD_LAT:0]             p1_v;
  logic [RD_LAT:0]             p2_v;
  logic                        p2_tail_unused;

  assign p1_d[0] = cap1_c;
  assign p2_d[0] = cap2_c;
  assign p1_v[0] = rd_en;
  assign p2_v[0] = rd_en;

  for (genvar s = 0; s < int'(RD_LAT); s++) begin : g_pipe
    regfile_rd_stage #(.DATA_W(DATA_W)) u_stage1 (
      .clk     (clk),
      .reset_n (reset_n),
      .vld_in  (p1_v[s]),
      .d       (p1_d[s]),
      .vld_out (p1_v[s+1]),
      .q       (p1_d[s+1])
    );
    regfile_rd_stage #(.DATA_W(DATA_W)) u_stage2 (
      .clk     (clk),
      .reset_n (reset_n),
      .vld_in  (p2_v[s]),
      .d       (p2_d[s]),
      .vld_out (p2_v[s+1]),
      .q       (p2_d[s+1])
    );
  end

  // Both ports' valid chains are identical; port 1 drives rd_valid.
  assign p2_tail_unused = p2_v[RD_LAT];

  assign rd_data1 = p1_d[RD_LAT];
  assign rd_data2 = p2_d[RD_LAT];
  assign rd_valid = p1_v[RD_LAT];

endmodule
